// File: rtl/bridge_stream_pkg.sv
// Shared types and constants for the bridge stream leaf.
// Contents:
//   CTRL_CLR_OVF / CTRL_FLUSH : bit positions in a CTRL register write
//   entry_t                   : one buffered bridge write (word offset + data)
//   status_t                  : layout of the CTRL register read value
//   bswap32                   : byte-order reversal of a 32-bit word
package bridge_stream_pkg;

  localparam int unsigned CTRL_CLR_OVF = 0;
  localparam int unsigned CTRL_FLUSH   = 1;

  // Wide enough for any word offset taken from addr[31:2].
  localparam int unsigned ENTRY_AW = 30;

  typedef struct packed {
    logic [ENTRY_AW-1:0] addr;
    logic [31:0]         data;
  } entry_t;

  typedef struct packed {
    logic [15:0] drop_count;
    logic        overflow;
    logic [5:0]  pad;
    logic [8:0]  level;
  } status_t;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/bridge_stream_fifo.sv
// Synchronous FIFO of entry_t with a registered (1-cycle) read port.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   push         : write push_data (caller guarantees !full || pop)
//   pop          : advance read side; pop_data updates at the next edge
//   flush        : discard all entries; overrides push and pop
//   pop_data     : most recently popped entry, held until the next pop
//   full, empty  : occupancy flags
//   count        : number of entries held in the RAM
module bridge_stream_fifo
  import bridge_stream_pkg::*;
#(
  parameter int unsigned DEPTH = 256
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  input  logic                   flush,
  output entry_t                 pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  entry_t        pop_data_q;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // RAM array carries no reset. When full, a push and pop hit the same slot;
  // the read below sees the old contents, which is the entry being popped.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pop_data_q <= '0;
    end else if (pop && !flush) begin
      pop_data_q <= mem[rd_ptr_q];
    end
  end

  assign pop_data = pop_data_q;
  assign full     = (count_q == (PW + 1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;

endmodule

// File: rtl/bridge_stream_leaf.sv
// Bridge responder leaf: absorbs bridge writes into a data window and replays
// them as a valid/ready stream of {word offset, data}. Writes cannot be stalled,
// so overflowing writes are dropped and counted in a readable status register.
// Ports:
//   clk, reset_n        : bridge clock, asynchronous active-low reset
//   bridge_addr/wr/...  : bridge responder side (addr, wr, wr_data, rd, rd_data)
//   out_valid/out_ready : stream handshake
//   out_addr            : word offset within the data window
//   out_data            : word, byte-swapped unless ENDIAN_LITTLE
//   overflow            : sticky, at least one write dropped
module bridge_stream_leaf
  import bridge_stream_pkg::*;
#(
  parameter int unsigned DEPTH         = 256,
  parameter int unsigned DATA_WORDS    = 262144,
  parameter logic        ENDIAN_LITTLE = 1'b0,
  localparam int unsigned AW           = $clog2(DATA_WORDS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [31:0]   bridge_addr,
  input  logic          bridge_wr,
  input  logic [31:0]   bridge_wr_data,
  input  logic          bridge_rd,
  output logic [31:0]   bridge_rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr,
  output logic [31:0]   out_data,
  output logic          overflow
);

  localparam logic [31:0] CTRL_ADDR = DATA_WORDS * 4;

  logic        aligned, hit_data, hit_ctrl;
  logic        data_wr, flush, clr, pop, accept, drop;
  logic        fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  entry_t      push_entry, pop_entry;
  logic [31:0] level_wide;
  status_t     status;

  logic        out_valid_q, out_valid_d;
  logic        overflow_q, overflow_d;
  logic [15:0] drop_count_q, drop_count_d;
  logic [31:0] rd_data_q, rd_data_d;

  assign aligned  = (bridge_addr[1:0] == 2'b00);
  assign hit_data = aligned && (bridge_addr < CTRL_ADDR);
  assign hit_ctrl = aligned && (bridge_addr == CTRL_ADDR);

  assign data_wr = bridge_wr && hit_data;
  assign flush   = bridge_wr && hit_ctrl && bridge_wr_data[CTRL_FLUSH];
  assign clr     = bridge_wr && hit_ctrl && bridge_wr_data[CTRL_CLR_OVF];

  // Refill the output stage whenever it is empty or being consumed.
  assign pop    = !fifo_empty && (!out_valid_q || out_ready) && !flush;
  assign accept = data_wr && !flush && (!fifo_full || pop);
  assign drop   = data_wr && !flush && !accept;

  assign push_entry.addr = bridge_addr[31:2];
  assign push_entry.data = bridge_wr_data;

  bridge_stream_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (accept),
    .push_data(push_entry),
    .pop      (pop),
    .flush    (flush),
    .pop_data (pop_entry),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Level counts the word parked in the output stage as well.
  assign level_wide = 32'(fifo_count) + 32'(out_valid_q);

  always_comb begin
    status.drop_count = drop_count_q;
    status.overflow   = overflow_q;
    status.pad        = '0;
    status.level      = (level_wide > 32'd511) ? 9'h1FF : level_wide[8:0];
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    rd_data_d    = rd_data_q;

    if (flush)          out_valid_d = 1'b0;
    else if (pop)       out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;

    if (clr) begin
      overflow_d   = 1'b0;
      drop_count_d = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
    end

    if (bridge_rd) rd_data_d = hit_ctrl ? status : 32'h0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q  <= 1'b0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
      rd_data_q    <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // Offset bits above the window are always zero for accepted writes.
  logic unused_addr_hi;
  assign unused_addr_hi = ^pop_entry.addr[ENTRY_AW-1:AW];

  assign out_valid      = out_valid_q;
  assign out_addr       = pop_entry.addr[AW-1:0];
  assign out_data       = ENDIAN_LITTLE ? pop_entry.data : bswap32(pop_entry.data);
  assign overflow       = overflow_q;
  assign bridge_rd_data = rd_data_q;

endmodule

// File: tb/tb_bridge_stream_leaf.sv
// Directed self-checking bench for bridge_stream_leaf (DEPTH=256,
// DATA_WORDS=262144 so CTRL sits at 0x0010_0000, ENDIAN_LITTLE=0).
module tb_bridge_stream_leaf;

  localparam logic [31:0] CTRL = 32'h0010_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] bridge_addr = '0;
  logic        bridge_wr = 1'b0;
  logic [31:0] bridge_wr_data = '0;
  logic        bridge_rd = 1'b0;
  logic [31:0] bridge_rd_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [17:0] out_addr;
  logic [31:0] out_data;
  logic        overflow;

  int n_cmp = 0;
  int n_bad = 0;

  bridge_stream_leaf dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .bridge_addr   (bridge_addr),
    .bridge_wr     (bridge_wr),
    .bridge_wr_data(bridge_wr_data),
    .bridge_rd     (bridge_rd),
    .bridge_rd_data(bridge_rd_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_addr      (out_addr),
    .out_data      (out_data),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bwrite(input logic [31:0] a, input logic [31:0] d);
    bridge_addr    = a;
    bridge_wr_data = d;
    bridge_wr      = 1'b1;
    tick();
    bridge_wr      = 1'b0;
  endtask

  task automatic bread(input logic [31:0] a, output logic [31:0] r);
    bridge_addr = a;
    bridge_rd   = 1'b1;
    tick();
    bridge_rd   = 1'b0;
    r           = bridge_rd_data;
  endtask

  function automatic logic [31:0] swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  logic [31:0] rd;

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_addr", 32'(out_addr), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_rdata", bridge_rd_data, 32'd0);
    reset_n = 1'b1;
    tick();

    // Single word latency and byte swap
    out_ready = 1'b1;
    bwrite(32'h10, 32'hAABB_CCDD);
    chk("t1_valid_n1", 32'(out_valid), 32'd0);
    tick();
    chk("t1_valid_n2", 32'(out_valid), 32'd1);
    chk("t1_addr", 32'(out_addr), 32'd4);
    chk("t1_data", out_data, 32'hDDCC_BBAA);
    tick();
    chk("t1_valid_done", 32'(out_valid), 32'd0);

    // 260 writes with consumer stalled: 257 kept, 3 dropped
    out_ready = 1'b0;
    for (int i = 0; i < 260; i++) begin
      bridge_addr    = 32'(i) * 4;
      bridge_wr_data = 32'h1000_0000 + 32'(i);
      bridge_wr      = 1'b1;
      tick();
    end
    bridge_wr = 1'b0;
    chk("t2_ovf", 32'(overflow), 32'd1);
    chk("t2_valid", 32'(out_valid), 32'd1);
    bread(CTRL, rd);
    chk("t2_status", rd, 32'h0003_8101);

    // Full FIFO: push with a simultaneous pop is accepted
    chk("t3_addr0", 32'(out_addr), 32'd0);
    chk("t3_data0", out_data, 32'h0000_0010);
    out_ready      = 1'b1;
    bridge_addr    = 32'h800;
    bridge_wr_data = 32'hCAFE_F00D;
    bridge_wr      = 1'b1;
    tick();
    bridge_wr = 1'b0;
    for (int k = 1; k <= 256; k++) begin
      chk("t3_drain_valid", 32'(out_valid), 32'd1);
      chk("t3_drain_addr", 32'(out_addr), 32'(k));
      chk("t3_drain_data", out_data, swap(32'h1000_0000 + 32'(k)));
      tick();
    end
    chk("t3_extra_addr", 32'(out_addr), 32'h200);
    chk("t3_extra_data", out_data, 32'h0DF0_FECA);
    tick();
    chk("t3_empty", 32'(out_valid), 32'd0);
    bread(CTRL, rd);
    chk("t3_status", rd, 32'h0003_8000);

    // Flush + clear with 10 words buffered
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bwrite(32'h40 + 32'(i) * 4, 32'(i));
    end
    tick();
    bread(CTRL, rd);
    chk("t4_status_pre", rd, 32'h0003_800A);
    bwrite(CTRL, 32'h3);
    chk("t4_valid", 32'(out_valid), 32'd0);
    chk("t4_ovf", 32'(overflow), 32'd0);
    tick();
    chk("t4_valid_hold", 32'(out_valid), 32'd0);
    bread(CTRL, rd);
    chk("t4_status", rd, 32'h0);

    // Misaligned and out-of-window writes are ignored
    bwrite(32'h13, 32'h1111_1111);
    bwrite(CTRL + 32'd4, 32'h2222_2222);
    tick();
    tick();
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_ovf", 32'(overflow), 32'd0);
    bread(CTRL, rd);
    chk("t5_status", rd, 32'h0);
    bwrite(32'h20, 32'h0102_0304);
    bread(CTRL, rd);
    chk("t5_level1", rd, 32'h1);
    bread(32'h13, rd);
    chk("t5_misaligned_rd", rd, 32'h0);
    chk("t5_valid_word", 32'(out_valid), 32'd1);
    chk("t5_word_addr", 32'(out_addr), 32'd8);

    // Reset mid-stream
    #2 reset_n = 1'b0;
    #1;
    chk("t6_valid_rst", 32'(out_valid), 32'd0);
    chk("t6_addr_rst", 32'(out_addr), 32'd0);
    chk("t6_data_rst", out_data, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    bwrite(32'h30, 32'h5566_7788);
    chk("t6_valid_n1", 32'(out_valid), 32'd0);
    tick();
    chk("t6_valid_n2", 32'(out_valid), 32'd1);
    chk("t6_addr", 32'(out_addr), 32'hC);
    chk("t6_data", out_data, 32'h8877_6655);
    out_ready = 1'b1;
    tick();
    chk("t6_alone", 32'(out_valid), 32'd0);
    bread(CTRL, rd);
    chk("t6_status", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
